// File: rtl/mp_add_sequencer.sv
// Multi-word adder sequencer: streams operand chunks (LS first) through an external
// combinational WIDTH-bit adder, chaining the carry between chunks via a register.
module mp_add_sequencer #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4,
    localparam int IW = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_first,
    input  logic             in_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_last,
    output logic [IW-1:0]    out_idx,
    output logic             out_err
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [IW-1:0] LastCount = IW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   count_q, count_d;

    logic             s1Valid_q;
    logic [WIDTH-1:0] s1A_q, s1B_q;
    logic             s1Cin_q, s1First_q, s1Last_q, s1Err_q;
    logic [IW-1:0]    s1Idx_q;

    logic             s2Valid_q;
    logic [WIDTH-1:0] s2Sum_q;
    logic             s2Cout_q, s2Last_q, s2Err_q;
    logic [IW-1:0]    s2Idx_q;

    logic             carry_q;

    logic          adv1, adv2, accept;
    logic [IW-1:0] chunkIdx;
    logic          chunkFirst, chunkLast, chunkErr;

    assign adv2     = !s2Valid_q || out_ready;
    assign adv1     = !s1Valid_q || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;

    // Chunk tagging: decides index, first/last and error for each accepted chunk.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        chunkIdx   = '0;
        chunkFirst = 1'b1;
        chunkLast  = in_last;
        chunkErr   = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    chunkErr = !in_first;
                    state_d  = in_last ? IDLE : BUSY;
                    count_d  = in_last ? '0 : IW'(1);
                end
                BUSY: begin
                    if (in_first) begin
                        chunkErr = 1'b1;
                        state_d  = in_last ? IDLE : BUSY;
                        count_d  = in_last ? '0 : IW'(1);
                    end else if (in_last || count_q == LastCount) begin
                        chunkIdx   = count_q;
                        chunkFirst = 1'b0;
                        chunkLast  = 1'b1;
                        chunkErr   = !in_last;
                        state_d    = IDLE;
                        count_d    = '0;
                    end else begin
                        chunkIdx   = count_q;
                        chunkFirst = 1'b0;
                        chunkLast  = 1'b0;
                        count_d    = count_q + IW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The adder only ever sees the S1 operands; an empty S1 presents zeros.
    assign add_a   = s1Valid_q ? s1A_q : '0;
    assign add_b   = s1Valid_q ? s1B_q : '0;
    assign add_cin = s1Valid_q && (s1First_q ? s1Cin_q : carry_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Cin_q   <= 1'b0;
            s1First_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Idx_q   <= '0;
            s1Err_q   <= 1'b0;
            s2Valid_q <= 1'b0;
            s2Sum_q   <= '0;
            s2Cout_q  <= 1'b0;
            s2Last_q  <= 1'b0;
            s2Idx_q   <= '0;
            s2Err_q   <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            if (adv2) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Sum_q  <= add_sum;
                    s2Cout_q <= s1Last_q && add_cout;
                    s2Last_q <= s1Last_q;
                    s2Idx_q  <= s1Idx_q;
                    s2Err_q  <= s1Err_q;
                    carry_q  <= add_cout;
                end
            end
            if (adv1) begin
                s1Valid_q <= accept;
                if (accept) begin
                    s1A_q     <= in_a;
                    s1B_q     <= in_b;
                    s1Cin_q   <= in_cin;
                    s1First_q <= chunkFirst;
                    s1Last_q  <= chunkLast;
                    s1Idx_q   <= chunkIdx;
                    s1Err_q   <= chunkErr;
                end
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_sum   = s2Sum_q;
    assign out_cout  = s2Cout_q;
    assign out_last  = s2Last_q;
    assign out_idx   = s2Idx_q;
    assign out_err   = s2Err_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer; the combinational adder is modelled here
// and every result chunk is compared against hand-computed values.
module tb_mp_add_sequencer;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_cin, in_first, in_last;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout, out_last, out_err;
    logic [IW-1:0]    out_idx;

    logic [WIDTH:0] adderResult;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       last;
        logic [1:0] idx;
        logic       err;
    } chunk_t;

    chunk_t obs[$];
    int checks = 0;
    int errors = 0;

    mp_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .in_first(in_first), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last),
        .out_idx(out_idx), .out_err(out_err)
    );

    assign adderResult = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_sum     = adderResult[WIDTH-1:0];
    assign add_cout    = adderResult[WIDTH];

    always #5 clk = ~clk;

    // Record every chunk that will be consumed on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            obs.push_back({out_sum, out_cout, out_last, out_idx, out_err});
    end

    function automatic chunk_t mk(logic [7:0] s, logic c, logic l, logic [1:0] i, logic e);
        return {s, c, l, i, e};
    endfunction

    task automatic checkValue(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkIdle(string tag);
        checkValue(tag, {out_valid, out_sum, out_cout, out_last, out_idx, out_err,
                         add_a, add_b, add_cin, in_ready}, 32'h0000_0001);
    endtask

    task automatic checkOutput(string tag, chunk_t exp);
        chunk_t got;
        int waitCycles = 0;
        while (obs.size() == 0 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checks++;
        assert (obs.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s no result chunk within 50 cycles", tag);
        end
        if (obs.size() != 0) begin
            got = obs.pop_front();
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("[TB] FAIL %s got sum=%h cout=%b last=%b idx=%0d err=%b expected sum=%h cout=%b last=%b idx=%0d err=%b",
                       tag, got.sum, got.cout, got.last, got.idx, got.err,
                       exp.sum, exp.cout, exp.last, exp.idx, exp.err);
            end
        end
    endtask

    task automatic applyStimulus(logic [7:0] a, logic [7:0] b, logic cin, logic first, logic last);
        int tries = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        checkValue("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkIdle("reset state");
        rst = 1'b0;

        // Single chunk with carry out, two-cycle latency.
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkValue("t1 latency cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkValue("t1 latency cycle2", {31'd0, out_valid}, 32'd1);
        checkOutput("t1 chunk", mk(8'h00, 1'b1, 1'b1, 2'd0, 1'b0));
        @(posedge clk); #1;

        // FFFFFFFF + 00000001 back-to-back.
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("t2 idx0", mk(8'h00, 1'b0, 1'b0, 2'd0, 1'b0));
        checkOutput("t2 idx1", mk(8'h00, 1'b0, 1'b0, 2'd1, 1'b0));
        checkOutput("t2 idx2", mk(8'h00, 1'b0, 1'b0, 2'd2, 1'b0));
        checkOutput("t2 idx3", mk(8'h00, 1'b1, 1'b1, 2'd3, 1'b0));
        @(posedge clk); #1;

        // Same operation with the downstream stalled once the first result shows up.
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
                applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
                applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
                applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checkValue("t3 first result", {31'd0, out_valid}, 32'd1);
                for (int i = 0; i < 5; i++) begin
                    checkValue("t3 stall in_ready", {31'd0, in_ready}, 32'd0);
                    checkValue("t3 stall hold", {29'd0, out_valid, out_idx}, {29'd0, 1'b1, 2'd0});
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        checkOutput("t3 idx0", mk(8'h00, 1'b0, 1'b0, 2'd0, 1'b0));
        checkOutput("t3 idx1", mk(8'h00, 1'b0, 1'b0, 2'd1, 1'b0));
        checkOutput("t3 idx2", mk(8'h00, 1'b0, 1'b0, 2'd2, 1'b0));
        checkOutput("t3 idx3", mk(8'h00, 1'b1, 1'b1, 2'd3, 1'b0));
        @(posedge clk); #1;

        // New in_first while an operation is open aborts it.
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h56, 8'h78, 1'b0, 1'b1, 1'b1);
        checkOutput("t4 open", mk(8'h46, 1'b0, 1'b0, 2'd0, 1'b0));
        checkOutput("t4 abort", mk(8'hCE, 1'b0, 1'b1, 2'd0, 1'b1));
        @(posedge clk); #1;

        // Five chunks without in_last: forced last at WORDS-1, then a headless op.
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        checkOutput("t5 idx0", mk(8'h02, 1'b0, 1'b0, 2'd0, 1'b0));
        checkOutput("t5 idx1", mk(8'h02, 1'b0, 1'b0, 2'd1, 1'b0));
        checkOutput("t5 idx2", mk(8'h02, 1'b0, 1'b0, 2'd2, 1'b0));
        checkOutput("t5 forced last", mk(8'h02, 1'b0, 1'b1, 2'd3, 1'b1));
        checkOutput("t5 missing first", mk(8'h02, 1'b0, 1'b0, 2'd0, 1'b1));
        @(posedge clk); #1;

        // Asynchronous reset mid-operation, then a clean two-chunk op.
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkIdle("t6 async reset");
        checkValue("t6 no leaked chunk", obs.size(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(8'h01, 8'hFF, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'h80, 1'b0, 1'b0, 1'b1);
        checkOutput("t6 idx0", mk(8'h01, 1'b0, 1'b0, 2'd0, 1'b0));
        checkOutput("t6 idx1", mk(8'h00, 1'b1, 1'b1, 2'd1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
